// File: rtl/ms_mul_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Imported by the interface, the arbiter and the scheduler top.
package ms_mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    HOLD
  } sched_state_e;

  // Wide enough for any TIMEOUT the scheduler is expected to see
  localparam int TIMEOUT_W = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_mul_rr_scheduler_if.sv
// Requester, response and multiplier-side signals of the scheduler.
// master = scheduler side, slave = fabric plus multiplier side.
interface ms_mul_rr_scheduler_if #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 1,
  parameter int NUM_REQ    = 4
);

  localparam int ID_W = ms_mul_sched_pkg::id_w(NUM_REQ);

  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ-1:0]                       req_ready;
  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data;

  logic                                     rsp_valid;
  logic                                     rsp_ready;
  logic [ID_W-1:0]                          rsp_id;
  logic [WXIP1-1:0]                         rsp_data;
  logic                                     rsp_err;

  logic                                     mul_rst;
  logic                                     mul_en;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]    mul_data_in;
  logic [WXIP1-1:0]                         mul_data_out;
  logic                                     mul_done;

  modport master (
    input  req_valid, req_data, rsp_ready, mul_data_out, mul_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           mul_rst, mul_en, mul_data_in
  );

  modport slave (
    output req_valid, req_data, rsp_ready, mul_data_out, mul_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           mul_rst, mul_en, mul_data_in
  );

endinterface

// File: rtl/ms_mul_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after
// last_grant+1 (wrapping) and returns it one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               found_o
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found_o     = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_i) + i) % NUM_REQ);
      if (!found_o && req_i[cand]) begin
        found_o       = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/ms_mul_rr_scheduler.sv
// Shares one serial multiplier between NUM_REQ requesters: grant, clear,
// run until done or timeout, then hold the tagged result until accepted.
module ms_mul_rr_scheduler
  import ms_mul_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 1,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                  clk,
  input logic                  rst,
  ms_mul_rr_scheduler_if.master bus
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int OPW  = NUM_INPUTS * DATA_WIDTH;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  sched_state_e                          state_q, state_d;
  logic [ID_W-1:0]                       last_grant_q, last_grant_d;
  logic [ID_W-1:0]                       id_q, id_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ops_q, ops_d;
  logic [WXIP1-1:0]                      data_q, data_d;
  logic                                  err_q, err_d;
  logic [TIMEOUT_W-1:0]                  cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               found;
  logic [OPW-1:0]     slices [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
    assign slices[r] = bus.req_data[r*OPW +: OPW];
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req_i       (bus.req_valid),
    .last_grant_i(last_grant_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .found_o     (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      ops_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      ops_q        <= ops_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Done is checked before the timeout so a coincident done still succeeds
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    ops_d        = ops_q;
    data_d       = data_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = CLR;
          last_grant_d = grant_idx;
          id_d         = grant_idx;
          ops_d        = slices[grant_idx];
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (bus.mul_done) begin
          data_d  = bus.mul_data_out;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == TO_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes are masked during reset so nothing leaks out mid-abort
  always_comb begin
    bus.req_ready   = '0;
    bus.mul_en      = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.mul_rst     = rst || (state_q == CLR);
    bus.rsp_id      = id_q;
    bus.rsp_data    = data_q;
    bus.rsp_err     = err_q;
    bus.mul_data_in = ops_q;
    if (!rst) begin
      case (state_q)
        IDLE:    bus.req_ready = grant;
        RUN:     bus.mul_en    = 1'b1;
        HOLD:    bus.rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_mul_rr_scheduler.sv
// Bench for ms_mul_rr_scheduler: stub multiplier plus a transaction-level
// model that predicts grant order and per-cycle outputs from grant offsets.
module tb_ms_mul_rr_scheduler;

  localparam int DW = 5;
  localparam int NI = 2;
  localparam int WX = 1;
  localparam int NR = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ms_mul_rr_scheduler_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX), .NUM_REQ(NR)) ifc ();

  ms_mul_rr_scheduler #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  logic [NR-1:0] vld;
  logic [DW-1:0] opnd [NR][NI];
  logic          rspRdy;
  logic          spuriousDone;
  int            stubK;
  int            stubCnt;
  bit            keepAll, randReady, randK;
  int            raiseProb, dropProb;

  int total, bad, cyc;

  bit            mBusy, postReset, inHold, sawValid;
  int            mOff, mLen, mId, mLast;
  logic [DW-1:0] mOp0, mOp1;
  logic          mErr, mRes;
  logic [NR-1:0] grantMask;
  int            grantLog [$];
  int            lastGrantCyc, validCyc, enCount;
  logic          obsErr;
  logic [WX-1:0] obsData;
  int            expOrder [5];

  // Stub multiplier: done during the stubK-th enabled cycle, 0 means never
  always @(posedge clk) begin
    if (ifc.mul_rst) stubCnt <= 0;
    else if (ifc.mul_en) stubCnt <= stubCnt + 1;
  end
  assign ifc.mul_done     = spuriousDone | (ifc.mul_en && (stubK != 0) && (stubCnt == stubK - 1));
  assign ifc.mul_data_out = ifc.mul_data_in[0][0] ^ ifc.mul_data_in[1][0];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus();
    logic [NR*NI*DW-1:0] packed_data;
    packed_data = '0;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NI; k++)
        packed_data[(r*NI+k)*DW +: DW] = opnd[r][k];
    ifc.req_data  = packed_data;
    ifc.req_valid = vld;
    ifc.rsp_ready = rspRdy;
  endtask

  task automatic newData(input int r);
    opnd[r][0] = DW'($urandom);
    opnd[r][1] = DW'($urandom);
  endtask

  // Reference model: expectations derive from the offset since the grant
  task automatic modelCycle();
    logic [NR-1:0] expReady;
    logic          expEn, expMulRst, expValid;
    bit            found;
    int            g;
    expReady  = '0;
    expEn     = 1'b0;
    expMulRst = 1'b0;
    expValid  = 1'b0;
    found     = 0;
    g         = 0;
    grantMask = '0;
    inHold    = 0;
    cyc++;
    if (ifc.mul_en === 1'b1) enCount++;
    if (ifc.rsp_valid === 1'b1 && !sawValid) begin
      sawValid = 1;
      validCyc = cyc;
    end
    if (rst) begin
      expMulRst = 1'b1;
      mBusy     = 0;
      mLast     = NR - 1;
      postReset = 1;
    end else begin
      if (postReset) begin
        checkOutput("reset_rsp_id", ifc.rsp_id, 0);
        checkOutput("reset_rsp_data", ifc.rsp_data, 0);
        checkOutput("reset_rsp_err", ifc.rsp_err, 0);
        checkOutput("reset_mul_data_in", ifc.mul_data_in, 0);
        postReset = 0;
      end
      if (!mBusy) begin
        for (int i = 1; i <= NR; i++) begin
          if (!found && vld[(mLast + i) % NR]) begin
            found = 1;
            g     = (mLast + i) % NR;
          end
        end
        if (found) begin
          expReady[g]  = 1'b1;
          grantMask[g] = 1'b1;
          mBusy        = 1;
          mOff         = 1;
          mId          = g;
          mOp0         = opnd[g][0];
          mOp1         = opnd[g][1];
          mErr         = !(stubK >= 1 && stubK <= TO);
          mLen         = mErr ? TO : stubK;
          mRes         = mErr ? 1'b0 : (mOp0[0] ^ mOp1[0]);
          mLast        = g;
          grantLog.push_back(g);
          lastGrantCyc = cyc;
          sawValid     = 0;
        end
      end else begin
        if (mOff == 1) expMulRst = 1'b1;
        else if (mOff <= 1 + mLen) expEn = 1'b1;
        else begin
          expValid = 1'b1;
          inHold   = 1;
          checkOutput("rsp_id", ifc.rsp_id, mId);
          checkOutput("rsp_data", ifc.rsp_data, mRes);
          checkOutput("rsp_err", ifc.rsp_err, mErr);
          if (rspRdy) begin
            mBusy   = 0;
            obsErr  = ifc.rsp_err;
            obsData = ifc.rsp_data;
          end
        end
        checkOutput("mul_data_in", ifc.mul_data_in, {mOp1, mOp0});
        mOff++;
      end
    end
    checkOutput("req_ready", ifc.req_ready, expReady);
    checkOutput("mul_en", ifc.mul_en, expEn);
    checkOutput("mul_rst", ifc.mul_rst, expMulRst);
    checkOutput("rsp_valid", ifc.rsp_valid, expValid);
  endtask

  task automatic tick();
    @(negedge clk);
    modelCycle();
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (grantMask[r]) begin
        if (keepAll) newData(r);
        else vld[r] = 1'b0;
      end else if (!vld[r] && raiseProb > 0 && $urandom_range(0, 99) < raiseProb) begin
        vld[r] = 1'b1;
        newData(r);
      end else if (vld[r] && dropProb > 0 && $urandom_range(0, 99) < dropProb) begin
        vld[r] = 1'b0;
      end
    end
    if (randReady) rspRdy = ($urandom_range(0, 99) < 70);
    if (randK && !mBusy) stubK = $urandom_range(0, 9);
    spuriousDone = 1'b0;
    applyStimulus();
  endtask

  task automatic runUntilQuiet(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((mBusy || vld != '0) && n < budget);
    checkOutput({tag, "_quiet"}, (mBusy || vld != '0) ? 1 : 0, 0);
  endtask

  task automatic runUntilHold(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!inHold && n < budget);
    checkOutput({tag, "_hold"}, inHold ? 1 : 0, 1);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    vld = '0; rspRdy = 1'b1; spuriousDone = 1'b0; stubK = 6;
    keepAll = 0; randReady = 0; randK = 0; raiseProb = 0; dropProb = 0;
    mBusy = 0; mLast = NR - 1; postReset = 0; inHold = 0; sawValid = 0;
    mOff = 0; mLen = 0; mId = 0; mOp0 = '0; mOp1 = '0; mErr = 1'b0; mRes = 1'b0;
    lastGrantCyc = 0; validCyc = 0; enCount = 0; obsErr = 1'b0; obsData = '0;
    expOrder = '{0, 1, 2, 3, 0};
    for (int r = 0; r < NR; r++) newData(r);
    rst = 1'b1;
    applyStimulus();
    repeat (3) tick();

    // Single request with the stub finishing after six enabled cycles
    rst = 1'b0;
    opnd[0][0] = 5'd1;
    opnd[0][1] = 5'd3;
    vld[0] = 1'b1;
    applyStimulus();
    runUntilQuiet(100, "single");
    checkOutput("single_latency", validCyc - lastGrantCyc, 8);
    checkOutput("single_data", obsData, 0);

    // All requesters valid straight out of reset
    rst = 1'b1;
    vld = '1;
    keepAll = 1;
    stubK = 2;
    applyStimulus();
    repeat (2) tick();
    rst = 1'b0;
    grantLog.delete();
    applyStimulus();
    for (int n = 0; n < 200 && grantLog.size() < 5; n++) tick();
    checkOutput("rr_count", (grantLog.size() >= 5) ? 1 : 0, 1);
    if (grantLog.size() >= 5)
      for (int i = 0; i < 5; i++) checkOutput($sformatf("rr_order%0d", i), grantLog[i], expOrder[i]);
    keepAll = 0;
    runUntilQuiet(300, "rr_drain");

    // Backpressure: response held for ten cycles before acceptance
    stubK = 3;
    rspRdy = 1'b0;
    vld[1] = 1'b1; newData(1);
    vld[2] = 1'b1; newData(2);
    applyStimulus();
    runUntilHold(100, "bp");
    repeat (9) tick();
    rspRdy = 1'b1;
    applyStimulus();
    runUntilQuiet(100, "bp");

    // Timeout with a silent stub, then done coinciding with the last cycle
    stubK = 0;
    enCount = 0;
    vld[3] = 1'b1; newData(3);
    applyStimulus();
    runUntilQuiet(200, "timeout");
    checkOutput("timeout_en_cycles", enCount, 64);
    checkOutput("timeout_err", obsErr, 1);
    checkOutput("timeout_data", obsData, 0);
    stubK = 64;
    enCount = 0;
    opnd[0][0] = 5'd1;
    opnd[0][1] = 5'd0;
    vld[0] = 1'b1;
    applyStimulus();
    runUntilQuiet(200, "done64");
    checkOutput("done64_en_cycles", enCount, 64);
    checkOutput("done64_err", obsErr, 0);
    checkOutput("done64_data", obsData, 1);

    // Reset pulse in the middle of a run
    stubK = 20;
    vld[2] = 1'b1; newData(2);
    applyStimulus();
    for (int n = 0; n < 50 && !(mBusy && mOff >= 6); n++) tick();
    checkOutput("midrun_reached", (mBusy && mOff >= 6) ? 1 : 0, 1);
    rst = 1'b1;
    vld[0] = 1'b1; newData(0);
    applyStimulus();
    tick();
    rst = 1'b0;
    stubK = 4;
    grantLog.delete();
    applyStimulus();
    runUntilQuiet(100, "abort");
    checkOutput("abort_grants", grantLog.size(), 1);
    if (grantLog.size() > 0) checkOutput("abort_first_grant", grantLog[0], 0);

    // Requester 2 withdraws; a stray done pulse while idle is ignored
    spuriousDone = 1'b1;
    applyStimulus();
    tick();
    grantLog.delete();
    vld[1] = 1'b1; newData(1);
    vld[2] = 1'b1; newData(2);
    vld[3] = 1'b1; newData(3);
    applyStimulus();
    tick();
    vld[2] = 1'b0;
    applyStimulus();
    runUntilQuiet(100, "skip");
    checkOutput("skip_grants", grantLog.size(), 2);
    if (grantLog.size() >= 2) begin
      checkOutput("skip_first", grantLog[0], 1);
      checkOutput("skip_second", grantLog[1], 3);
    end

    // Randomized traffic, backpressure and multiplier latency
    raiseProb = 25;
    dropProb = 2;
    randReady = 1;
    randK = 1;
    repeat (600) tick();
    raiseProb = 0;
    dropProb = 0;
    randReady = 0;
    rspRdy = 1'b1;
    applyStimulus();
    runUntilQuiet(600, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
